// File: rtl/display_pkg.sv
// Shared types and width helpers for the result display sequencer.
// Index and count widths are derived from the buffer depth.
package display_pkg;

  typedef enum logic {
    FILL = 1'b0,
    SHOW = 1'b1
  } state_e;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/result_display_sequencer_if.sv
// Fill-side handshake, display controls and display outputs
// of the result display sequencer as one bundle.
interface result_display_sequencer_if #(
  parameter int unsigned width_p = 8,
  parameter int unsigned iw_p    = 2,
  parameter int unsigned cw_p    = 3
);

  logic               valid;
  logic [width_p-1:0] data;
  logic               ready;
  logic               flush;
  logic               mode;
  logic               step;
  logic               loop;
  logic               clear;
  logic               disp_valid;
  logic [width_p-1:0] disp_data;
  logic [iw_p-1:0]    disp_idx;
  logic [cw_p-1:0]    count;

  modport master (
    output valid, data, flush, mode,
    output step, loop, clear,
    input  ready, disp_valid, disp_data,
    input  disp_idx, count
  );

  modport slave (
    input  valid, data, flush, mode,
    input  step, loop, clear,
    output ready, disp_valid, disp_data,
    output disp_idx, count
  );

endinterface

// File: rtl/dwell_timer.sv
// Auto-advance dwell counter: runs 0..cycles_p-1 while enabled,
// done_o marks the terminal count and the counter wraps there.
module dwell_timer #(
  parameter int unsigned cycles_p = 60000000
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  input  logic clear_i,
  output logic done_o
);

  localparam int cw = $clog2(cycles_p);
  localparam logic [cw-1:0] last_c = cw'(cycles_p - 1);

  logic [cw-1:0] cnt;

  assign done_o = en_i && !clear_i && (cnt == last_c);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (en_i) begin
      cnt <= done_o ? '0 : cnt + cw'(1);
    end
  end

endmodule

// File: rtl/result_display_sequencer.sv
// Buffers up to depth_p result words, then shows them one at a time,
// advancing on a dwell timer (auto) or on step pulses (manual).
module result_display_sequencer
  import display_pkg::*;
#(
  parameter int unsigned width_p        = 8,
  parameter int unsigned depth_p        = 4,
  parameter int unsigned dwell_cycles_p = 60000000
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       valid_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  input  logic                       flush_i,
  input  logic                       mode_i,
  input  logic                       step_i,
  input  logic                       loop_i,
  input  logic                       clear_i,
  output logic                       disp_valid_o,
  output logic [width_p-1:0]         disp_data_o,
  output logic [idx_w(depth_p)-1:0]  disp_idx_o,
  output logic [cnt_w(depth_p)-1:0]  count_o
);

  localparam int iw = idx_w(depth_p);
  localparam int cw = cnt_w(depth_p);
  localparam logic [cw-1:0] full_c = cw'(depth_p);

  state_e             state, state_n;
  logic [cw-1:0]      count, count_n;
  logic               dv, dv_n;
  logic [width_p-1:0] dd, dd_n;
  logic [iw-1:0]      di, di_n;
  logic               mode_q;
  logic               acc, wr, adv;
  logic               last, mode_chg;
  logic               done, t_en, t_clr;
  logic [width_p-1:0] mem [depth_p];

  assign ready_o      = (state == FILL) && (count < full_c);
  assign acc          = valid_i && ready_o;
  assign mode_chg     = mode_i != mode_q;
  assign last         = cw'(di) == (count - cw'(1));
  assign disp_valid_o = dv;
  assign disp_data_o  = dd;
  assign disp_idx_o   = di;
  assign count_o      = count;

  assign t_en  = (state == SHOW) && !mode_i;
  assign t_clr = (state != SHOW) || mode_i
              || mode_chg || clear_i;

  dwell_timer #(
    .cycles_p (dwell_cycles_p)
  ) u_dwell (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (t_en),
    .clear_i   (t_clr),
    .done_o    (done)
  );

  assign adv = (state == SHOW) && !mode_chg
            && (mode_i ? step_i : done);

  always_comb begin
    state_n = state;
    count_n = count;
    dv_n    = dv;
    dd_n    = dd;
    di_n    = di;
    wr      = 1'b0;
    unique case (state)
      FILL: begin
        if (clear_i) begin
          count_n = '0;
        end else begin
          wr      = acc;
          count_n = count + cw'(acc);
          if (count_n == full_c
              || (flush_i && count_n != '0)) begin
            state_n = SHOW;
            dv_n    = 1'b1;
            di_n    = '0;
            dd_n    = (count == '0) ? data_i : mem[0];
          end
        end
      end
      SHOW: begin
        if (clear_i || (adv && last && !loop_i)) begin
          state_n = FILL;
          count_n = '0;
          dv_n    = 1'b0;
          dd_n    = '0;
          di_n    = '0;
        end else if (adv) begin
          di_n = last ? '0 : di + iw'(1);
          dd_n = mem[di_n];
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= FILL;
      count  <= '0;
      dv     <= 1'b0;
      dd     <= '0;
      di     <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      dv     <= dv_n;
      dd     <= dd_n;
      di     <= di_n;
      mode_q <= mode_i;
    end
  end

  // Buffer storage is not reset; count alone defines what is live.
  always_ff @(posedge clk_i) begin
    if (wr) mem[iw'(count)] <= data_i;
  end

endmodule

// File: tb/tb_result_display_sequencer.sv
// Directed and random stimulus against a queue-based display model.
module tb_result_display_sequencer;
  import display_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int DW = 5;
  localparam int IW = idx_w(D);
  localparam int CW = cnt_w(D);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  result_display_sequencer_if #(
    .width_p (W),
    .iw_p    (IW),
    .cw_p    (CW)
  ) bus ();

  result_display_sequencer #(
    .width_p        (W),
    .depth_p        (D),
    .dwell_cycles_p (DW)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .valid_i      (bus.valid),
    .data_i       (bus.data),
    .ready_o      (bus.ready),
    .flush_i      (bus.flush),
    .mode_i       (bus.mode),
    .step_i       (bus.step),
    .loop_i       (bus.loop),
    .clear_i      (bus.clear),
    .disp_valid_o (bus.disp_valid),
    .disp_data_o  (bus.disp_data),
    .disp_idx_o   (bus.disp_idx),
    .count_o      (bus.count)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h want=%0h",
               tag, $time, got, exp);
    end
  endtask

  bit [W-1:0] q[$];
  bit showing;
  int pos;
  int dwell;
  bit last_mode;

  task automatic model_reset();
    q.delete();
    showing = 0;
    pos = 0;
    dwell = 0;
    last_mode = 0;
  endtask

  task automatic model_step();
    bit adv;
    adv = 0;
    if (!showing) begin
      if (bus.clear) q.delete();
      else begin
        if (bus.valid && q.size() < D)
          q.push_back(bus.data);
        if (q.size() == D || (bus.flush && q.size() > 0)) begin
          showing = 1;
          pos = 0;
          dwell = 0;
        end
      end
    end else if (bus.clear) begin
      showing = 0;
      q.delete();
    end else begin
      if (bus.mode != last_mode) begin
        dwell = 0;
      end else if (bus.mode) begin
        adv = bus.step;
        dwell = 0;
      end else begin
        adv = (dwell == DW - 1);
        dwell = adv ? 0 : dwell + 1;
      end
      if (adv) begin
        if (pos == q.size() - 1) begin
          if (bus.loop) pos = 0;
          else begin
            showing = 0;
            q.delete();
          end
        end else pos++;
      end
    end
    last_mode = bus.mode;
  endtask

  task automatic compare();
    chk("disp_valid", 32'(bus.disp_valid), 32'(showing));
    chk("disp_idx", 32'(bus.disp_idx), showing ? pos : 0);
    chk("disp_data", 32'(bus.disp_data),
        showing ? 32'(q[pos]) : 0);
    chk("count", 32'(bus.count), q.size());
    chk("ready", 32'(bus.ready),
        32'(!showing && q.size() < D));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    else model_reset();
    #1;
    compare();
  endtask

  task automatic idle();
    bus.valid = 0;
    bus.flush = 0;
    bus.step = 0;
    bus.clear = 0;
  endtask

  task automatic push(input logic [W-1:0] d);
    bus.valid = 1;
    bus.data = d;
    tick();
    bus.valid = 0;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset lands between edges; outputs must drop immediately.
  task automatic async_reset();
    #2;
    reset_n = 0;
    #1;
    model_reset();
    compare();
    tick();
    reset_n = 1;
  endtask

  task automatic pulse_step();
    bus.step = 1;
    tick();
    bus.step = 0;
  endtask

  initial begin
    int exp_idx[5];
    exp_idx = '{1, 2, 3, 0, 1};
    bus.valid = 0;
    bus.data = '0;
    bus.flush = 0;
    bus.mode = 0;
    bus.step = 0;
    bus.loop = 0;
    bus.clear = 0;
    model_reset();
    #12;
    compare();
    reset_n = 1;

    push(8'h12);
    push(8'h34);
    push(8'h56);
    push(8'h78);
    chk("show_entry_data", 32'(bus.disp_data), 32'h12);
    wait_n(5);
    chk("second_entry", 32'(bus.disp_data), 32'h34);
    wait_n(16);
    chk("back_to_fill_ready", 32'(bus.ready), 1);

    push(8'hA1);
    push(8'hB2);
    bus.flush = 1;
    tick();
    bus.flush = 0;
    chk("flush_count", 32'(bus.count), 2);
    wait_n(12);
    chk("flush_done", 32'(bus.disp_valid), 0);

    bus.flush = 1;
    tick();
    bus.flush = 0;
    chk("empty_flush", 32'(bus.disp_valid), 0);

    bus.mode = 1;
    bus.loop = 1;
    tick();
    for (int i = 0; i < D; i++) push(8'(8'h40 + i));
    for (int k = 0; k < 5; k++) begin
      wait_n(19);
      pulse_step();
      chk("manual_idx", 32'(bus.disp_idx), exp_idx[k]);
    end
    pulse_step();
    chk("manual_idx2", 32'(bus.disp_idx), 2);
    bus.step = 1;
    bus.clear = 1;
    tick();
    idle();
    chk("clear_valid", 32'(bus.disp_valid), 0);
    chk("clear_count", 32'(bus.count), 0);

    bus.mode = 0;
    bus.loop = 0;
    bus.valid = 1;
    for (int i = 0; i < 6; i++) begin
      bus.data = 8'($urandom);
      tick();
    end
    bus.valid = 0;
    chk("overfill_count", 32'(bus.count), 4);
    wait_n(3);
    async_reset();
    chk("post_reset_ready", 32'(bus.ready), 1);
    for (int i = 0; i < D; i++) push(8'($urandom));
    wait_n(8);

    for (int c = 0; c < 3000; c++) begin
      bus.valid = 1'($urandom_range(0, 1));
      bus.data = 8'($urandom);
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.clear = ($urandom_range(0, 59) == 0);
      bus.step = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 39) == 0) bus.loop = ~bus.loop;
      if ($urandom_range(0, 499) == 0) async_reset();
      else tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
